// File: rtl/bram_spi_tx_pkg.sv
// Shared definitions for the BRAM-to-SPI transmit path: FSM encoding and
// default geometry, reused by bram_storage and the SPI receive side.
package bram_spi_tx_pkg;
    localparam int BRAM_ADDR_W = 10;
    localparam int SPI_CLK_DIV = 4;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT,
        SHIFT,
        NEXT,
        FINISH
    } tx_state_t;
endpackage

// File: rtl/bram_spi_tx_shifter.sv
// SPI mode-0 byte serializer: MSB first, CLK_DIV clks per SCLK half-period,
// byte_done is combinational so the parent leaves SHIFT on the final edge.
module spi_byte_shifter import bram_spi_tx_pkg::*; #(
    parameter int CLK_DIV = SPI_CLK_DIV
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] byte_in,
    output logic       sclk,
    output logic       mosi,
    output logic       byte_done
);
    logic [6:0] sreg;
    logic [7:0] div_cnt;
    logic [3:0] phase;
    logic       active;
    logic       phase_end;

    assign phase_end = active && (div_cnt == 8'(CLK_DIV - 1));
    assign byte_done = phase_end && (phase == 4'd15);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sreg    <= '0;
            div_cnt <= '0;
            phase   <= '0;
            active  <= 1'b0;
            sclk    <= 1'b0;
            mosi    <= 1'b0;
        end else if (load) begin
            sreg    <= byte_in[6:0];
            mosi    <= byte_in[7];
            sclk    <= 1'b0;
            div_cnt <= '0;
            phase   <= '0;
            active  <= 1'b1;
        end else if (active) begin
            if (phase_end) begin
                div_cnt <= '0;
                phase   <= phase + 4'd1;
                if (phase == 4'd15) begin
                    active <= 1'b0;
                    sclk   <= 1'b0;
                end else begin
                    sclk <= ~sclk;
                    // next bit goes out only on the falling edge
                    if (sclk) begin
                        mosi <= sreg[6];
                        sreg <= {sreg[5:0], 1'b0};
                    end
                end
            end else begin
                div_cnt <= div_cnt + 8'd1;
            end
        end
    end
endmodule

// File: rtl/bram_spi_tx.sv
// Streams length bytes from a 1-cycle-latency BRAM out over SPI mode 0,
// starting at base_addr with address wrap; owns FSM, addressing and counters.
module bram_spi_tx import bram_spi_tx_pkg::*; #(
    parameter int CLK_DIV = SPI_CLK_DIV,
    parameter int ADDR_W  = BRAM_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   length,
    output logic [ADDR_W-1:0] bram_addr,
    input  logic [7:0]        bram_rd_data,
    output logic              spi_sclk,
    output logic              spi_mosi,
    output logic              spi_cs_n,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   byte_count
);
    typedef struct packed {
        logic [ADDR_W-1:0] base;
        logic [ADDR_W:0]   len;
    } xfer_req_t;

    localparam logic [ADDR_W:0] ONE = 1;

    tx_state_t         state;
    xfer_req_t         req;
    logic              load;
    logic              byte_done;
    logic [ADDR_W:0]   next_count;
    logic [ADDR_W-1:0] next_addr;

    assign next_count = byte_count + ONE;
    assign next_addr  = req.base + next_count[ADDR_W-1:0];

    // bram_addr is registered on the edge entering FETCH so the BRAM samples it
    // at the end of FETCH and its data is stable throughout WAIT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            req        <= '0;
            bram_addr  <= '0;
            byte_count <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            spi_cs_n   <= 1'b1;
            load       <= 1'b0;
        end else begin
            done <= 1'b0;
            load <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        byte_count <= '0;
                        if (length == '0) begin
                            done <= 1'b1;
                        end else begin
                            req.base  <= base_addr;
                            req.len   <= length;
                            bram_addr <= base_addr;
                            busy      <= 1'b1;
                            spi_cs_n  <= 1'b0;
                            state     <= FETCH;
                        end
                    end
                end
                FETCH: begin
                    load  <= 1'b1;
                    state <= WAIT;
                end
                WAIT:  state <= SHIFT;
                SHIFT: if (byte_done) state <= NEXT;
                NEXT: begin
                    byte_count <= next_count;
                    if (next_count < req.len) begin
                        bram_addr <= next_addr;
                        state     <= FETCH;
                    end else begin
                        spi_cs_n <= 1'b1;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        state    <= FINISH;
                    end
                end
                FINISH:  state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    spi_byte_shifter #(.CLK_DIV(CLK_DIV)) u_shifter (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .byte_in  (bram_rd_data),
        .sclk     (spi_sclk),
        .mosi     (spi_mosi),
        .byte_done(byte_done)
    );
endmodule

// File: tb/tb_bram_spi_tx.sv
// Directed bench: dut_a (CLK_DIV=2) for the short transfers, dut_b (CLK_DIV=1)
// for the full 1024-byte stream; received bytes checked against a queue.
module tb_bram_spi_tx;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] mem [1024];
    int checks = 0;
    int errors = 0;

    logic        a_start = 1'b0, b_start = 1'b0;
    logic [9:0]  a_base = '0, b_base = '0;
    logic [10:0] a_len = '0, b_len = '0;
    logic [9:0]  a_addr, b_addr;
    logic [7:0]  a_rd, b_rd;
    logic        a_sclk, a_mosi, a_cs_n, a_busy, a_done;
    logic        b_sclk, b_mosi, b_cs_n, b_busy, b_done;
    logic [10:0] a_cnt, b_cnt;

    bram_spi_tx #(.CLK_DIV(2), .ADDR_W(10)) dut_a (
        .clk(clk), .rst(rst), .start(a_start), .base_addr(a_base), .length(a_len),
        .bram_addr(a_addr), .bram_rd_data(a_rd), .spi_sclk(a_sclk), .spi_mosi(a_mosi),
        .spi_cs_n(a_cs_n), .busy(a_busy), .done(a_done), .byte_count(a_cnt));

    bram_spi_tx #(.CLK_DIV(1), .ADDR_W(10)) dut_b (
        .clk(clk), .rst(rst), .start(b_start), .base_addr(b_base), .length(b_len),
        .bram_addr(b_addr), .bram_rd_data(b_rd), .spi_sclk(b_sclk), .spi_mosi(b_mosi),
        .spi_cs_n(b_cs_n), .busy(b_busy), .done(b_done), .byte_count(b_cnt));

    always @(posedge clk) a_rd <= mem[a_addr];
    always @(posedge clk) b_rd <= mem[b_addr];

    logic [7:0] a_exp_q [$];
    logic [7:0] b_exp_q [$];
    logic [9:0] a_alog [$];
    int a_rises = 0, a_nb = 0, a_done_cnt = 0, a_busy_cyc = 0, a_cs_falls = 0;
    int b_rises = 0, b_nb = 0, b_busy_cyc = 0, b_cs_falls = 0, b_cs_rises = 0;
    int b_cyc = 0, b_last = 0, b_n2 = 0, b_n5 = 0, b_nbad = 0, b_hrun = 0, b_hmax = 0;
    bit b_have_last = 1'b0;
    logic [7:0] a_sh = '0, b_sh = '0;
    logic a_cs_q = 1'b1, b_cs_q = 1'b1, b_sclk_q = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // byte scoreboards, sampled on SCLK rise (mode 0)
    initial forever begin
        @(posedge a_sclk or posedge rst);
        if (rst) begin
            a_nb = 0;
            a_exp_q.delete();
        end else begin
            a_rises++;
            a_sh = {a_sh[6:0], a_mosi};
            a_nb++;
            if (a_nb == 8) begin
                a_nb = 0;
                check("a_q_has_entry", 32'(a_exp_q.size() != 0), 32'd1);
                if (a_exp_q.size() != 0) check("a_byte", 32'(a_sh), 32'(a_exp_q.pop_front()));
            end
        end
    end

    initial forever begin
        @(posedge b_sclk or posedge rst);
        if (rst) begin
            b_nb = 0;
        end else begin
            b_rises++;
            b_sh = {b_sh[6:0], b_mosi};
            b_nb++;
            if (b_nb == 8) begin
                b_nb = 0;
                check("b_q_has_entry", 32'(b_exp_q.size() != 0), 32'd1);
                if (b_exp_q.size() != 0) check("b_byte", 32'(b_sh), 32'(b_exp_q.pop_front()));
            end
        end
    end

    // per-clock sampler, 2 time units after the rising edge
    initial forever begin
        @(posedge clk);
        #2;
        if (a_done) a_done_cnt++;
        if (a_busy) begin
            a_busy_cyc++;
            if (a_alog.size() == 0 || a_addr != a_alog[$]) a_alog.push_back(a_addr);
        end
        if (!a_cs_n && a_cs_q) a_cs_falls++;
        a_cs_q = a_cs_n;
        b_cyc++;
        if (b_busy) b_busy_cyc++;
        if (!b_cs_n && b_cs_q) b_cs_falls++;
        if (b_cs_n && !b_cs_q) b_cs_rises++;
        b_cs_q = b_cs_n;
        if (b_sclk && !b_sclk_q) begin
            if (b_have_last) begin
                if (b_cyc - b_last == 2) b_n2++;
                else if (b_cyc - b_last == 5) b_n5++;
                else b_nbad++;
            end
            b_last = b_cyc;
            b_have_last = 1'b1;
        end
        b_hrun = b_sclk ? b_hrun + 1 : 0;
        if (b_hrun > b_hmax) b_hmax = b_hrun;
        b_sclk_q = b_sclk;
    end

    task automatic start_a(input int base, input int len, input bit run);
        if (run) for (int i = 0; i < len; i++) a_exp_q.push_back(mem[10'(base + i)]);
        a_base = 10'(base); a_len = 11'(len); a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
    endtask

    task automatic wait_done_a(input int budget, input string tag);
        int n = 0;
        while (!a_done && n < budget) begin @(negedge clk); n++; end
        check(tag, 32'(a_done), 32'd1);
    endtask

    initial begin
        int r0, d0, bc0, f0, n;
        int exp_addr [4] = '{1022, 1023, 0, 1};
        for (int i = 0; i < 1024; i++) mem[i] = 8'(i * 7 + 3);
        mem[0] = 8'hA5; mem[1] = 8'h3C; mem[2] = 8'hFF; mem[3] = 8'h00;
        mem[1022] = 8'h5A; mem[1023] = 8'hC3; mem[18] = 8'h08;

        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_cs_n", 32'(a_cs_n), 32'd1);
        check("rst_sclk", 32'(a_sclk), 32'd0);
        check("rst_mosi", 32'(a_mosi), 32'd0);
        check("rst_busy", 32'(a_busy), 32'd0);
        check("rst_done", 32'(a_done), 32'd0);
        check("rst_addr", 32'(a_addr), 32'd0);
        check("rst_count", 32'(a_cnt), 32'd0);
        check("rst_b_cs_n", 32'(b_cs_n), 32'd1);

        // basic 4-byte transfer, started on the first edge after reset release
        r0 = a_rises; d0 = a_done_cnt; bc0 = a_busy_cyc;
        rst = 1'b0;
        start_a(0, 4, 1'b1);
        check("t1_busy", 32'(a_busy), 32'd1);
        check("t1_cs_low", 32'(a_cs_n), 32'd0);
        wait_done_a(400, "t1_done_seen");
        @(negedge clk);
        check("t1_done_width", 32'(a_done), 32'd0);
        check("t1_rises", 32'(a_rises - r0), 32'd32);
        check("t1_done_cnt", 32'(a_done_cnt - d0), 32'd1);
        check("t1_busy_cycles", 32'(a_busy_cyc - bc0), 32'd140);
        check("t1_count", 32'(a_cnt), 32'd4);
        check("t1_cs_high", 32'(a_cs_n), 32'd1);
        check("t1_q_empty", 32'(a_exp_q.size()), 32'd0);

        // address wrap 1022 -> 1
        a_alog.delete();
        start_a(1022, 4, 1'b1);
        wait_done_a(400, "t2_done_seen");
        @(negedge clk);
        check("t2_addr_cnt", 32'(a_alog.size()), 32'd4);
        for (int i = 0; i < 4; i++)
            if (i < a_alog.size()) check("t2_addr", 32'(a_alog[i]), 32'(exp_addr[i]));
        check("t2_count", 32'(a_cnt), 32'd4);
        check("t2_q_empty", 32'(a_exp_q.size()), 32'd0);

        // zero length: done only
        d0 = a_done_cnt; bc0 = a_busy_cyc; f0 = a_cs_falls;
        start_a(5, 0, 1'b0);
        check("t3_done", 32'(a_done), 32'd1);
        check("t3_busy", 32'(a_busy), 32'd0);
        @(negedge clk);
        check("t3_done_width", 32'(a_done), 32'd0);
        repeat (3) @(negedge clk);
        check("t3_cs_falls", 32'(a_cs_falls - f0), 32'd0);
        check("t3_busy_cycles", 32'(a_busy_cyc - bc0), 32'd0);
        check("t3_done_cnt", 32'(a_done_cnt - d0), 32'd1);

        // start while busy is ignored
        d0 = a_done_cnt; bc0 = a_busy_cyc;
        start_a(8, 3, 1'b1);
        repeat (40) @(negedge clk);
        start_a(100, 2, 1'b0);
        wait_done_a(400, "t4_done_seen");
        @(negedge clk);
        check("t4_count", 32'(a_cnt), 32'd3);
        check("t4_done_cnt", 32'(a_done_cnt - d0), 32'd1);
        check("t4_busy_cycles", 32'(a_busy_cyc - bc0), 32'd105);
        check("t4_mosi_hold", 32'(a_mosi), 32'd1);
        check("t4_q_empty", 32'(a_exp_q.size()), 32'd0);

        // reset during bit 3 of byte index 2
        r0 = a_rises; d0 = a_done_cnt;
        start_a(16, 4, 1'b1);
        n = 0;
        while (a_rises < r0 + 20 && n < 1000) begin @(negedge clk); n++; end
        check("t5_reached_bit4", 32'(a_rises - r0), 32'd20);
        n = 0;
        while (a_sclk && n < 10) begin @(negedge clk); n++; end
        check("t5_bit3_mosi", 32'(a_mosi), 32'd1);
        check("t5_q_pending", 32'(a_exp_q.size()), 32'd2);
        #1 rst = 1'b1;
        #1;
        check("t5_cs_n", 32'(a_cs_n), 32'd1);
        check("t5_sclk", 32'(a_sclk), 32'd0);
        check("t5_busy", 32'(a_busy), 32'd0);
        check("t5_count", 32'(a_cnt), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("t5_no_done", 32'(a_done_cnt - d0), 32'd0);
        bc0 = a_busy_cyc;
        start_a(40, 2, 1'b1);
        wait_done_a(300, "t5_done_seen");
        @(negedge clk);
        check("t5_after_count", 32'(a_cnt), 32'd2);
        check("t5_after_busy", 32'(a_busy_cyc - bc0), 32'd70);
        check("t5_q_empty", 32'(a_exp_q.size()), 32'd0);

        // CLK_DIV=1, full 1024-byte stream
        r0 = b_rises; bc0 = b_busy_cyc; f0 = b_cs_falls; d0 = b_cs_rises;
        for (int i = 0; i < 1024; i++) b_exp_q.push_back(mem[i]);
        b_base = '0; b_len = 11'd1024; b_start = 1'b1;
        @(negedge clk);
        b_start = 1'b0;
        n = 0;
        while (!b_done && n < 20000) begin @(negedge clk); n++; end
        check("t6_done_seen", 32'(b_done), 32'd1);
        @(negedge clk);
        check("t6_rises", 32'(b_rises - r0), 32'd8192);
        check("t6_count", 32'(b_cnt), 32'd1024);
        check("t6_busy_cycles", 32'(b_busy_cyc - bc0), 32'd19456);
        check("t6_cs_falls", 32'(b_cs_falls - f0), 32'd1);
        check("t6_cs_rises", 32'(b_cs_rises - d0), 32'd1);
        check("t6_in_byte_periods", 32'(b_n2), 32'd7168);
        check("t6_gap_periods", 32'(b_n5), 32'd1023);
        check("t6_bad_periods", 32'(b_nbad), 32'd0);
        check("t6_high_max", 32'(b_hmax), 32'd1);
        check("t6_q_empty", 32'(b_exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/bram_spi_tx.md
BRAM_SPI_TX -- requirements
Module: bram_spi_tx

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4: system clocks per SCLK half-period, legal range 1..255.
REQ-002 SHALL have parameter ADDR_W, default 10: BRAM address width, giving 1024 entries.
REQ-003 SHALL have port clk, input, 1: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-005 SHALL have port start, input, 1: transfer request, sampled only in IDLE.
REQ-006 SHALL have port base_addr, input, ADDR_W: first BRAM address to send, latched on start.
REQ-007 SHALL have port length, input, ADDR_W+1: number of bytes to send, 0..1024, latched on start.
REQ-008 SHALL have port bram_addr, output, ADDR_W: read address driven to the BRAM.
REQ-009 SHALL have port bram_rd_data, input, 8: BRAM read data, valid one clk after bram_addr.
REQ-010 SHALL have port spi_sclk, output, 1: SPI clock, mode 0, idles low.
REQ-011 SHALL have port spi_mosi, output, 1: serial data, MSB first.
REQ-012 SHALL have port spi_cs_n, output, 1: chip select, active-low.
REQ-013 SHALL have port busy, output, 1: high from the clk after start is accepted until done.
REQ-014 SHALL have port done, output, 1: one-clk pulse at the end of a transfer.
REQ-015 SHALL have port byte_count, output, ADDR_W+1: number of bytes fully shifted out in the current or last transfer.

Function
REQ-016 FSM SHALL have the states IDLE, FETCH, WAIT, SHIFT, NEXT and FINISH.
REQ-017 IDLE with start=1 and length>0 SHALL do the following at clk T: latch the inputs, set busy=1 and spi_cs_n=0 at T+1, and enter FETCH.
REQ-018 IDLE with start=1 and length=0 SHALL pulse done at T+1 and leave busy and spi_cs_n unchanged.
REQ-019 FETCH SHALL drive bram_addr = (base_addr + byte_count) mod 2^ADDR_W, wrapping 1023 to 0, then enter WAIT.
REQ-020 WAIT SHALL wait one clk to cover the BRAM read latency, then load bram_rd_data into an 8-bit shift register and enter SHIFT.
REQ-021 SHIFT SHALL present bit 7 on spi_mosi with spi_sclk low for CLK_DIV clks, then spi_sclk high for CLK_DIV clks, repeated for bits 6..0.
REQ-022 spi_mosi SHALL change only while spi_sclk is low, so each byte takes exactly 16*CLK_DIV clks in SHIFT.
REQ-023 NEXT SHALL increment byte_count, then enter FETCH if byte_count < length, else FINISH.
REQ-024 Between bytes, spi_sclk SHALL stay low and spi_cs_n SHALL stay low, giving a 3-clk gap (NEXT, FETCH, WAIT).
REQ-025 FINISH SHALL set spi_cs_n=1, busy=0 and done=1 for one clk, then return to IDLE.
REQ-026 start asserted while busy SHALL be ignored, and the latched base_addr and length SHALL not change.
REQ-027 byte_count SHALL be cleared on accepted start and held after done until the next start.
REQ-028 Outside SHIFT, spi_mosi SHALL hold the last value driven, and SHALL be 0 after reset.

Reset
REQ-029 rst=1 SHALL force IDLE immediately (asynchronous), including mid-transfer, aborting without a done pulse.
REQ-030 rst=1 SHALL set the output reset values: spi_cs_n=1, spi_sclk=0, spi_mosi=0, busy=0, done=0, bram_addr=0, byte_count=0.
REQ-031 The first start SHALL be accepted on the first clk edge after rst deasserts.

Structure
REQ-032 A shared package SHALL hold the FSM state encoding, ADDR_W and the default CLK_DIV, for reuse with bram_storage and the SPI receive path.
REQ-033 The block SHALL have one sub-module, spi_byte_shifter: it takes load and byte in, produces sclk and mosi out, and pulses byte_done, with CLK_DIV as its parameter.
REQ-034 The parent SHALL own the FSM, address generation and counters.

Verification
REQ-035 Bench SHALL cover: CLK_DIV=2, BRAM[0..3]=A5,3C,FF,00, start with base=0, length=4 -> MOSI bits 10100101 00111100 11111111 00000000, 32 SCLK rises, done once, byte_count=4.
REQ-036 Bench SHALL cover: base=1022, length=4 -> bram_addr sequence 1022,1023,0,1; BRAM contents received in that order.
REQ-037 Bench SHALL cover: length=0 -> done pulses one clk after start; spi_cs_n never falls; busy stays 0.
REQ-038 Bench SHALL cover: start re-pulsed mid-transfer with base=100 -> ignored; the original bytes complete unchanged.
REQ-039 Bench SHALL cover: rst asserted during bit 3 of byte 2 -> spi_cs_n=1 and spi_sclk=0 within the same clk, no done; the next start runs normally.
REQ-040 Bench SHALL cover: CLK_DIV=1, length=1024 -> 1024 bytes, 8192 SCLK rises, spi_cs_n continuously low, and each SCLK high and low phase is 1 clk.
